// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier and restoring divider producing a hi/lo pair
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divzero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [WIDTH:0]    acc, acc_n, sum, mres, shl;
    logic [WIDTH-1:0]  mq, mq_n, b_r, a_r, ma, mb, quo, rem;
    logic [2*WIDTH-1:0] prod, prod_f;
    logic              is_div, neg_q, neg_r, ge, dz, accept, last;

    assign busy   = state == RUN;
    assign done   = state == DONE;
    assign accept = start && state != RUN;
    assign last   = cnt == CW'(WIDTH - 1);
    assign ma     = (op[0] && a[WIDTH-1]) ? -a : a;
    assign mb     = (op[0] && b[WIDTH-1]) ? -b : b;

    // one unsigned iteration of either core plus the sign fixup applied at the final edge
    always_comb begin
        sum    = {1'b0, acc[WIDTH-1:0]} + {1'b0, b_r};
        mres   = mq[0] ? sum : {1'b0, acc[WIDTH-1:0]};
        shl    = {acc[WIDTH-1:0], mq[WIDTH-1]};
        ge     = shl >= {1'b0, b_r};
        acc_n  = is_div ? (ge ? shl - {1'b0, b_r} : shl) : {1'b0, mres[WIDTH:1]};
        mq_n   = is_div ? {mq[WIDTH-2:0], ge} : {mres[0], mq[WIDTH-1:1]};
        prod   = {acc_n[WIDTH-1:0], mq_n};
        prod_f = neg_q ? -prod : prod;
        quo    = neg_q ? -mq_n : mq_n;
        rem    = neg_r ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
        dz     = is_div && b_r == '0;
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // next state: DONE may relaunch directly when start is held
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN:     state_n = last ? DONE : RUN;
            default: state_n = start ? RUN : IDLE;
        endcase
    end

    // operand latch at accept, iteration during RUN, result commit on the last iteration
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            acc     <= '0;
            mq      <= '0;
            b_r     <= '0;
            a_r     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            divzero <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            acc    <= '0;
            mq     <= ma;
            b_r    <= mb;
            a_r    <= a;
            is_div <= op[1];
            neg_q  <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= op[0] && a[WIDTH-1];
        end else if (state == RUN) begin
            acc <= acc_n;
            mq  <= mq_n;
            cnt <= cnt + CW'(1);
            if (last) begin
                divzero <= dz;
                hi      <= dz ? a_r : (is_div ? rem : prod_f[2*WIDTH-1:WIDTH]);
                lo      <= dz ? '1 : (is_div ? quo : prod_f[WIDTH-1:0]);
            end
        end
    end
endmodule
